// File: rtl/icepic_lib_pkg.sv
// Shared types and constants for the icepic program loader.
// The loader's FSM state set and the UART receiver's state set live here so the
// top and the receiver agree on encodings.
package icepic_lib_pkg;

    localparam int INST_ADDR_W = 12;
    localparam int INST_W      = 12;

    localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_CNT_HI,
        LD_CNT_LO,
        LD_W_HI,
        LD_W_LO,
        LD_CHECK,
        LD_DONE,
        LD_ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // A frame is in progress in every state between the sync byte and the verdict.
    function automatic logic loader_busy(input loader_state_t s);
        return (s == LD_CNT_HI) || (s == LD_CNT_LO) || (s == LD_W_HI) ||
               (s == LD_W_LO)   || (s == LD_CHECK);
    endfunction

endpackage

// File: rtl/icepic_uart_rx.sv
// 8N1 UART receiver for the program loader.
// rx_in is double-registered, a falling edge opens a frame, the start bit is
// re-checked half a bit later, then data bits and the stop bit are sampled mid-bit.
// byte_valid_out pulses one cycle after the stop-bit sample; frame_err_out rides
// with it when the stop bit was low.
module icepic_uart_rx
    import icepic_lib_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk_in,
    input  logic       reset_n_in,
    input  logic       rx_in,
    output logic [7:0] byte_out,
    output logic       byte_valid_out,
    output logic       frame_err_out
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_sync_p0;
    logic             rx_sync_p1;
    logic             rx_prev_p2;
    logic             rx_fall;
    rx_state_t        state_q;
    rx_state_t        state_d;
    logic [CNT_W-1:0] clk_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             tick;

    // Two-flop synchronizer plus one history flop for edge detection; idles high.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            rx_prev_p2 <= 1'b1;
        end else begin
            rx_sync_p0 <= rx_in;
            rx_sync_p1 <= rx_sync_p0;
            rx_prev_p2 <= rx_sync_p1;
        end
    end

    assign rx_fall  = rx_prev_p2 & ~rx_sync_p1;
    assign byte_out = shift_q;

    // Receiver state register.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a high line at the half-bit point means the start was a glitch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:  if (rx_fall) state_d = RX_START;
            RX_START: if (tick) state_d = rx_sync_p1 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && (bit_idx_q == 3'd7)) state_d = RX_STOP;
            RX_STOP:  if (tick) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    // Sample strobe: half a bit into the start bit, a full bit for every later sample.
    always_comb begin
        tick = 1'b0;
        case (state_q)
            RX_START:         tick = (clk_cnt_q == HALF_M1);
            RX_DATA, RX_STOP: tick = (clk_cnt_q == FULL_M1);
            default:          tick = 1'b0;
        endcase
    end

    // Bit timer and bit index; both restart on every sample.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
        end else begin
            if ((state_q == RX_IDLE) || tick) clk_cnt_q <= '0;
            else                              clk_cnt_q <= clk_cnt_q + 1'b1;

            if (state_q != RX_DATA) bit_idx_q <= '0;
            else if (tick)          bit_idx_q <= bit_idx_q + 1'b1;
        end
    end

    // Data bits arrive LSB first, so shift in from the top.
    always_ff @(posedge clk_in) begin
        if ((state_q == RX_DATA) && tick) shift_q <= {rx_sync_p1, shift_q[7:1]};
    end

    // Byte strobe and stop-bit error, registered one cycle after the stop sample.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            byte_valid_out <= 1'b0;
            frame_err_out  <= 1'b0;
        end else begin
            byte_valid_out <= (state_q == RX_STOP) && tick;
            frame_err_out  <= (state_q == RX_STOP) && tick && !rx_sync_p1;
        end
    end

endmodule

// File: rtl/icepic_prog_loader.sv
// Program loader: receives a program image over UART and writes 12-bit
// instruction words into the write port of the instruction memory, holding the
// CPU in reset until an image has been accepted.
// Frame: A5, CNT_HI, CNT_LO, then N words of two bytes (hi nibble, lo byte).
// Optional build macro ICEPIC_LOADER_CHECKSUM_EN adds a trailing CHK byte that
// must equal the modulo-256 sum of CNT_HI, CNT_LO and every word byte.
module icepic_prog_loader
    import icepic_lib_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter bit BOOT_HOLD    = 1'b1
) (
    input  logic                   clk_in,
    input  logic                   reset_n_in,
    input  logic                   rx_in,
    output logic                   cpu_reset_out,
    output logic                   wr_en_out,
    output logic [INST_ADDR_W-1:0] wr_addr_out,
    output logic [INST_W-1:0]      wr_data_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   err_out
);

`ifdef ICEPIC_LOADER_CHECKSUM_EN
    localparam loader_state_t TAIL_STATE = LD_CHECK;
`else
    localparam loader_state_t TAIL_STATE = LD_DONE;
`endif

    logic [7:0]             rx_byte;
    logic                   rx_valid;
    logic                   rx_ferr;
    logic                   byte_ok;
    loader_state_t          state_q;
    loader_state_t          state_d;
    logic [3:0]             cnt_hi_q;
    logic [INST_ADDR_W-1:0] word_cnt_q;
    logic [INST_ADDR_W-1:0] addr_cnt_q;
    logic [3:0]             word_hi_q;
    logic [INST_ADDR_W-1:0] n_words;
    logic                   last_word;
    logic                   idle_like;
    logic                   busy_d;
    logic                   done_d;
    logic                   err_d;
    logic                   cpu_reset_d;
    logic                   wr_en_d;
`ifdef ICEPIC_LOADER_CHECKSUM_EN
    logic [7:0]             sum_q;
`endif

    icepic_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .clk_in        (clk_in),
        .reset_n_in    (reset_n_in),
        .rx_in         (rx_in),
        .byte_out      (rx_byte),
        .byte_valid_out(rx_valid),
        .frame_err_out (rx_ferr)
    );

    assign byte_ok   = rx_valid & ~rx_ferr;
    assign n_words   = {cnt_hi_q, rx_byte};
    assign last_word = (addr_cnt_q == (word_cnt_q - 1'b1));
    assign idle_like = (state_q == LD_IDLE) || (state_q == LD_DONE) || (state_q == LD_ERROR);

    // Loader state register.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= LD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a bad stop bit aborts an open frame but is ignored between frames.
    always_comb begin
        state_d = state_q;
        if (rx_valid) begin
            if (rx_ferr) begin
                if (loader_busy(state_q)) state_d = LD_ERROR;
            end else begin
                case (state_q)
                    LD_IDLE, LD_DONE, LD_ERROR: begin
                        if (rx_byte == LOADER_SYNC_BYTE) state_d = LD_CNT_HI;
                    end
                    LD_CNT_HI: state_d = (rx_byte[7:4] != 4'h0) ? LD_ERROR : LD_CNT_LO;
                    LD_CNT_LO: state_d = (n_words == '0) ? TAIL_STATE : LD_W_HI;
                    LD_W_HI:   state_d = LD_W_LO;
                    LD_W_LO:   state_d = last_word ? TAIL_STATE : LD_W_HI;
`ifdef ICEPIC_LOADER_CHECKSUM_EN
                    LD_CHECK:  state_d = (rx_byte == sum_q) ? LD_DONE : LD_ERROR;
`endif
                    default:   state_d = LD_ERROR;
                endcase
            end
        end
    end

    // Status outputs follow the state being entered; the CPU runs only after a clean load.
    always_comb begin
        busy_d      = loader_busy(state_d);
        done_d      = (state_d == LD_DONE);
        err_d       = (state_d == LD_ERROR);
        cpu_reset_d = 1'b1;
        if (state_d == LD_DONE)      cpu_reset_d = 1'b0;
        else if (state_d == LD_IDLE) cpu_reset_d = BOOT_HOLD;
        wr_en_d     = byte_ok && (state_q == LD_W_LO);
    end

    // Registered outputs; address and data hold their last write between strobes.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            cpu_reset_out <= BOOT_HOLD;
            busy_out      <= 1'b0;
            done_out      <= 1'b0;
            err_out       <= 1'b0;
            wr_en_out     <= 1'b0;
            wr_addr_out   <= '0;
            wr_data_out   <= '0;
        end else begin
            cpu_reset_out <= cpu_reset_d;
            busy_out      <= busy_d;
            done_out      <= done_d;
            err_out       <= err_d;
            wr_en_out     <= wr_en_d;
            if (wr_en_d) begin
                wr_addr_out <= addr_cnt_q;
                wr_data_out <= {word_hi_q, rx_byte};
            end
        end
    end

    // Word address counter: cleared by an accepted sync byte, bumped after each write.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            addr_cnt_q <= '0;
        end else if (byte_ok) begin
            if (idle_like && (rx_byte == LOADER_SYNC_BYTE)) addr_cnt_q <= '0;
            else if (state_q == LD_W_LO)                    addr_cnt_q <= addr_cnt_q + 1'b1;
        end
    end

    // Frame header and word high-nibble capture.
    always_ff @(posedge clk_in) begin
        if (byte_ok) begin
            case (state_q)
                LD_CNT_HI: cnt_hi_q   <= rx_byte[3:0];
                LD_CNT_LO: word_cnt_q <= n_words;
                LD_W_HI:   word_hi_q  <= rx_byte[3:0];
                default:   ;
            endcase
        end
    end

`ifdef ICEPIC_LOADER_CHECKSUM_EN
    // Running modulo-256 sum of every byte after the sync byte, up to the CHK byte.
    always_ff @(posedge clk_in) begin
        if (byte_ok) begin
            case (state_q)
                LD_IDLE, LD_DONE, LD_ERROR: sum_q <= '0;
                LD_CNT_HI:                  sum_q <= rx_byte;
                LD_CNT_LO, LD_W_HI, LD_W_LO: sum_q <= sum_q + rx_byte;
                default:                    ;
            endcase
        end
    end
`endif

endmodule
